// File: rtl/idct_transpose_buf.sv
// Transpose buffer between the column and row 4-point IDCT passes.
// Serial row-major samples in, clipped columns out, ping-pong banks.
module idct_transpose_buf #(
    parameter int DATA_W = 25,
    parameter int CLIP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] d_out_1,
    output logic [DATA_W-1:0] d_out_2,
    output logic [DATA_W-1:0] d_out_3,
    output logic [DATA_W-1:0] d_out_4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              clip_evt
);

    localparam logic signed [DATA_W-1:0] MAXV = DATA_W'((2 ** (CLIP_W - 1)) - 1);
    localparam logic signed [DATA_W-1:0] MINV = DATA_W'(-(2 ** (CLIP_W - 1)));

    logic [CLIP_W-1:0] mem [0:1][0:15];
    logic [3:0]        wcnt;
    logic              wbank;
    logic [1:0]        rcnt;
    logic              rbank;
    logic [1:0]        full;

    logic              wr_en;
    logic              rd_en;
    logic              sat;
    logic [CLIP_W-1:0] clip_val;

    function automatic logic [DATA_W-1:0] sext(input logic [CLIP_W-1:0] v);
        return {{(DATA_W - CLIP_W){v[CLIP_W-1]}}, v};
    endfunction

    always_comb begin
        sat      = 1'b0;
        clip_val = in_data[CLIP_W-1:0];
        if ($signed(in_data) > MAXV) begin
            sat      = 1'b1;
            clip_val = MAXV[CLIP_W-1:0];
        end else if ($signed(in_data) < MINV) begin
            sat      = 1'b1;
            clip_val = MINV[CLIP_W-1:0];
        end
    end

    assign in_ready  = !full[wbank];
    assign out_valid = full[rbank];
    assign out_last  = out_valid && (rcnt == 2'd3);
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready;

    // Row i of the block sits at index {i, col}, so a column is a fixed-stride pick.
    assign d_out_1 = sext(mem[rbank][{2'd0, rcnt}]);
    assign d_out_2 = sext(mem[rbank][{2'd1, rcnt}]);
    assign d_out_3 = sext(mem[rbank][{2'd2, rcnt}]);
    assign d_out_4 = sext(mem[rbank][{2'd3, rcnt}]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wcnt     <= '0;
            wbank    <= 1'b0;
            rcnt     <= '0;
            rbank    <= 1'b0;
            full     <= '0;
            clip_evt <= 1'b0;
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < 16; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else begin
            clip_evt <= 1'b0;
            if (wr_en) begin
                mem[wbank][wcnt] <= clip_val;
                clip_evt         <= sat;
                if (wcnt == 4'd15) begin
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                    wcnt        <= '0;
                end else begin
                    wcnt <= wcnt + 4'd1;
                end
            end
            // Reads only touch a full bank, writes only a non-full one: never the same bit.
            if (rd_en) begin
                if (rcnt == 2'd3) begin
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                    rcnt        <= '0;
                end else begin
                    rcnt <= rcnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Self-checking bench for idct_transpose_buf: table vectors plus a scoreboard
// of expected column beats built from an independent block model.
module tb_idct_transpose_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [24:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] d_out_1, d_out_2, d_out_3, d_out_4;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        clip_evt;

    idct_transpose_buf #(.DATA_W(25), .CLIP_W(16)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .d_out_1(d_out_1), .d_out_2(d_out_2),
        .d_out_3(d_out_3), .d_out_4(d_out_4), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .clip_evt(clip_evt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][24:0] d;
        bit               last;
    } beat_t;

    typedef struct {
        logic [24:0] din;
        logic [15:0] stored;
        bit          clipped;
    } vec_t;

    int               total = 0;
    int               bad = 0;
    beat_t            q[$];
    logic [15:0]      blk [16];
    int               wk = 0;
    bit               clip_pend = 0;
    bit               prev_stall = 0;
    logic [3:0][24:0] prev_d;
    logic             prev_last;
    vec_t             vt [16];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [24:0] sx(input logic [15:0] v);
        return {{9{v[15]}}, v};
    endfunction

    function automatic logic [15:0] clipf(input logic signed [24:0] d);
        if (d > 25'sd32767) return 16'h7fff;
        if (d < -25'sd32768) return 16'h8000;
        return d[15:0];
    endfunction

    // Called at a negedge: drive inputs, check outputs against the model, advance one cycle.
    task automatic cycle(input bit vi, input logic [24:0] d, input bit ordy,
                         input logic [15:0] expv, input bit expc);
        int               nfull;
        bit               acc;
        bit               beat;
        logic [3:0][24:0] dn;
        beat_t            nb;
        nfull = (q.size() + 3) / 4;
        in_valid = vi; in_data = d; out_ready = ordy;
        #1;
        dn = {d_out_4, d_out_3, d_out_2, d_out_1};
        chk("in_ready", in_ready, nfull < 2);
        chk("out_valid", out_valid, q.size() != 0);
        chk("clip_evt", clip_evt, clip_pend);
        if (q.size() != 0) begin
            for (int i = 0; i < 4; i++) chk($sformatf("d_out_%0d", i + 1), dn[i], q[0].d[i]);
            chk("out_last", out_last, q[0].last);
        end else begin
            chk("out_last_idle", out_last, 0);
        end
        if (prev_stall) chk("stall_hold", {dn, out_last}, {prev_d, prev_last});
        acc  = vi && (nfull < 2);
        beat = (q.size() != 0) && ordy;
        prev_stall = (q.size() != 0) && !ordy;
        prev_d = dn; prev_last = out_last;
        if (beat) void'(q.pop_front());
        clip_pend = acc && expc;
        if (acc) begin
            blk[wk] = expv;
            wk++;
            if (wk == 16) begin
                for (int j = 0; j < 4; j++) begin
                    for (int i = 0; i < 4; i++) nb.d[i] = sx(blk[4 * i + j]);
                    nb.last = (j == 3);
                    q.push_back(nb);
                end
                wk = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc(input bit vi, input logic [24:0] d, input bit ordy);
        logic [15:0] cv;
        cv = clipf(d);
        cycle(vi, d, ordy, cv, (cv != d[15:0]) || (sx(cv) != d));
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && q.size() != 0; n++) cyc(0, '0, 1);
        chk("drain_timeout", q.size(), 0);
        cyc(0, '0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        q.delete(); wk = 0; clip_pend = 0; prev_stall = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_clip_evt", clip_evt, 0);
        chk("rst_d_out", {d_out_4, d_out_3, d_out_2, d_out_1}, 0);
    endtask

    initial begin
        vt[0]  = '{25'(40000),     16'h7fff, 1'b1};
        vt[1]  = '{25'(-40000),    16'h8000, 1'b1};
        vt[2]  = '{25'(32767),     16'h7fff, 1'b0};
        vt[3]  = '{25'(-32768),    16'h8000, 1'b0};
        vt[4]  = '{25'(0),         16'h0000, 1'b0};
        vt[5]  = '{25'(1),         16'h0001, 1'b0};
        vt[6]  = '{25'(-1),        16'hffff, 1'b0};
        vt[7]  = '{25'(32768),     16'h7fff, 1'b1};
        vt[8]  = '{25'(-32769),    16'h8000, 1'b1};
        vt[9]  = '{25'h0ffffff,    16'h7fff, 1'b1};
        vt[10] = '{25'h1000000,    16'h8000, 1'b1};
        vt[11] = '{25'(1234),      16'h04d2, 1'b0};
        vt[12] = '{25'(-1234),     16'hfb2e, 1'b0};
        vt[13] = '{25'(65536),     16'h7fff, 1'b1};
        vt[14] = '{25'(-100),      16'hff9c, 1'b0};
        vt[15] = '{25'(20000),     16'h4e20, 1'b0};

        do_reset();
        @(negedge clk);

        // Basic transpose of k = 0..15, then check the first beat one cycle later.
        for (int k = 0; k < 16; k++) cyc(1, 25'(k), 1);
        chk("t1_latency_valid", out_valid, 1);
        chk("t1_first_col", {d_out_4, d_out_3, d_out_2, d_out_1},
            {25'd12, 25'd8, 25'd4, 25'd0});
        drain();

        // Clip table.
        for (int k = 0; k < 16; k++) cycle(1, vt[k].din, 1, vt[k].stored, vt[k].clipped);
        drain();

        // Back-pressure: 33 offers with out_ready low, then drain.
        for (int k = 0; k < 33; k++) cyc(1, 25'(100 + k), 0);
        chk("t3_in_ready_low", in_ready, 0);
        drain();

        // Continuous streaming, four blocks.
        for (int k = 0; k < 64; k++) begin
            chk("t4_no_bubble", in_ready, 1);
            cyc(1, 25'($urandom_range(0, 70000)) - 25'd35000, 1);
        end
        drain();

        // Random out_ready / in_valid.
        for (int k = 0; k < 120; k++)
            cyc($urandom_range(0, 3) != 0, 25'($urandom), $urandom_range(0, 1) == 1);
        drain();

        // Reset in mid-block, then a clean block.
        for (int k = 0; k < 7; k++) cyc(1, 25'(500 + k), 1);
        do_reset();
        for (int k = 0; k < 16; k++) cyc(1, 25'(200 + k), 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
